// File: rtl/dcache_axi_bridge_pkg.sv
// Shared types and constants for the dcache <-> AXI4 bridge.
package dcache_axi_pkg;

  localparam int unsigned LINE_WORDS = 16;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_AR   = 3'b010,
    R_DATA = 3'b100
  } rd_state_e;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_AW   = 4'b0010,
    W_DATA = 4'b0100,
    W_RESP = 4'b1000
  } wr_state_e;

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI4 master-port bundle between the dcache bridge and the core interconnect.
interface dcache_axi_bridge_if;
  import dcache_axi_pkg::*;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/dcache_axi_bridge_axi_line_serializer.sv
// Holds a latched cache line and walks it out one 32-bit word per W handshake,
// starting at the request's word offset and wrapping at the line end.
module axi_line_serializer
  import dcache_axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 16,
  localparam int unsigned CNT_W     = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_load,
  input  logic [32*LINE_WORDS-1:0] i_line,
  input  logic [CNT_W-1:0]        i_start,
  input  logic [7:0]              i_len,
  input  logic                    i_adv,
  output logic [31:0]             o_wdata,
  output logic                    o_wlast
);

  logic [32*LINE_WORDS-1:0] r_line;
  logic [CNT_W-1:0]         r_cnt;
  logic [7:0]               r_beats;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_line  <= '0;
      r_cnt   <= '0;
      r_beats <= '0;
    end else if (i_load) begin
      r_line  <= i_line;
      r_cnt   <= i_start;
      r_beats <= '0;
    end else if (i_adv) begin
      r_cnt   <= r_cnt + 1'b1;
      r_beats <= r_beats + 8'd1;
    end
  end

  always_comb begin
    o_wdata = r_line[32*r_cnt +: 32];
    o_wlast = (r_beats == i_len);
  end

endmodule

// File: rtl/dcache_axi_bridge.sv
// Dcache miss/write-back responder: independent AXI4 read and write engines,
// with reads to a line that has a write in flight held off until it completes.
module dcache_axi_bridge
  import dcache_axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 16,
  parameter logic [3:0]  WR_ID      = 4'd1,
  parameter logic [3:0]  RD_ID      = 4'd1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     r_req,
  input  logic [31:0]              r_addr,
  input  logic [7:0]               r_length,
  input  logic [2:0]               r_size,
  output logic                     r_rdy,
  input  logic                     r_data_ready,
  output logic                     ret_valid,
  output logic [31:0]              ret_data,
  output logic                     ret_last,
  input  logic                     w_req,
  input  logic [31:0]              w_addr,
  input  logic [7:0]               w_length,
  input  logic [2:0]               w_size,
  input  logic [32*LINE_WORDS-1:0] w_line,
  input  logic [3:0]               w_strb,
  output logic                     w_rdy,
  output logic                     wrt_finish,
  dcache_axi_bridge_if.master      axi
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);

  rd_state_e   r_rd_state, w_rd_next;
  wr_state_e   r_wr_state, w_wr_next;

  logic [31:0] r_ar_addr;
  logic [7:0]  r_ar_len;
  logic [2:0]  r_ar_size;
  logic [31:0] r_aw_addr;
  logic [7:0]  r_aw_len;
  logic [2:0]  r_aw_size;
  logic [3:0]  r_w_strb;

  logic        w_hazard;
  logic        w_rd_accept;
  logic        w_wr_accept;
  logic        w_w_hs;
  logic [31:0] w_ser_data;
  logic        w_ser_last;

  // Same-line check uses the address above the line offset.
  always_comb begin
    w_hazard    = (r_wr_state != W_IDLE) &&
                  (r_addr[31:CNT_W+2] == r_aw_addr[31:CNT_W+2]);
    w_rd_accept = r_req && (r_rd_state == R_IDLE) && !w_hazard;
    w_wr_accept = w_req && (r_wr_state == W_IDLE);
    w_w_hs      = (r_wr_state == W_DATA) && axi.wready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_accept) w_rd_next = R_AR;
      R_AR:    if (axi.arready) w_rd_next = R_DATA;
      R_DATA:  if (axi.rvalid && r_data_ready && axi.rlast) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    r_rdy       = (r_rd_state == R_IDLE) && !w_hazard;
    axi.arvalid = (r_rd_state == R_AR);
    axi.arid    = (r_rd_state == R_AR) ? RD_ID : '0;
    axi.arburst = (r_rd_state == R_AR) ? BURST_INCR : '0;
    axi.araddr  = r_ar_addr;
    axi.arlen   = r_ar_len;
    axi.arsize  = r_ar_size;
    axi.rready  = (r_rd_state == R_DATA) && r_data_ready;
    ret_valid   = (r_rd_state == R_DATA) && axi.rvalid;
    ret_data    = (r_rd_state == R_DATA) ? axi.rdata : '0;
    ret_last    = (r_rd_state == R_DATA) && axi.rlast;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ar_addr <= '0;
      r_ar_len  <= '0;
      r_ar_size <= '0;
    end else if (w_rd_accept) begin
      r_ar_addr <= r_addr;
      r_ar_len  <= r_length;
      r_ar_size <= r_size;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_wr_accept) w_wr_next = W_AW;
      W_AW:    if (axi.awready) w_wr_next = W_DATA;
      W_DATA:  if (w_w_hs && w_ser_last) w_wr_next = W_RESP;
      W_RESP:  if (axi.bvalid) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rdy       = (r_wr_state == W_IDLE);
    axi.awvalid = (r_wr_state == W_AW);
    axi.awid    = (r_wr_state == W_AW) ? WR_ID : '0;
    axi.awburst = (r_wr_state == W_AW) ? BURST_INCR : '0;
    axi.awaddr  = r_aw_addr;
    axi.awlen   = r_aw_len;
    axi.awsize  = r_aw_size;
    axi.wvalid  = (r_wr_state == W_DATA);
    axi.wdata   = w_ser_data;
    axi.wlast   = (r_wr_state == W_DATA) && w_ser_last;
    axi.wstrb   = '0;
    if (r_wr_state == W_DATA) axi.wstrb = (r_aw_len == 8'd0) ? r_w_strb : 4'hF;
    axi.bready  = (r_wr_state == W_RESP);
    wrt_finish  = (r_wr_state == W_RESP) && axi.bvalid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_aw_addr <= '0;
      r_aw_len  <= '0;
      r_aw_size <= '0;
      r_w_strb  <= '0;
    end else if (w_wr_accept) begin
      r_aw_addr <= w_addr;
      r_aw_len  <= w_length;
      r_aw_size <= w_size;
      r_w_strb  <= w_strb;
    end
  end

  axi_line_serializer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_ser (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_wr_accept),
    .i_line  (w_line),
    .i_start (w_addr[CNT_W+1:2]),
    .i_len   (r_aw_len),
    .i_adv   (w_w_hs),
    .o_wdata (w_ser_data),
    .o_wlast (w_ser_last)
  );

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: inputs change on the falling edge,
// outputs are sampled 1ns later, state commits on the rising edge.
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rstn;
  logic         r_req;
  logic [31:0]  r_addr;
  logic [7:0]   r_length;
  logic [2:0]   r_size;
  logic         r_rdy;
  logic         r_data_ready;
  logic         ret_valid;
  logic [31:0]  ret_data;
  logic         ret_last;
  logic         w_req;
  logic [31:0]  w_addr;
  logic [7:0]   w_length;
  logic [2:0]   w_size;
  logic [511:0] w_line;
  logic [3:0]   w_strb;
  logic         w_rdy;
  logic         wrt_finish;

  logic [511:0] tb_line;
  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  dcache_axi_bridge_if axi ();

  dcache_axi_bridge #(
    .LINE_WORDS (16),
    .WR_ID      (4'd1),
    .RD_ID      (4'd1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .r_req        (r_req),
    .r_addr       (r_addr),
    .r_length     (r_length),
    .r_size       (r_size),
    .r_rdy        (r_rdy),
    .r_data_ready (r_data_ready),
    .ret_valid    (ret_valid),
    .ret_data     (ret_data),
    .ret_last     (ret_last),
    .w_req        (w_req),
    .w_addr       (w_addr),
    .w_length     (w_length),
    .w_size       (w_size),
    .w_line       (w_line),
    .w_strb       (w_strb),
    .w_rdy        (w_rdy),
    .wrt_finish   (wrt_finish),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int unsigned ar_wait, input string tag);
    int unsigned beat;
    int unsigned cyc;
    r_req = 1'b1; r_addr = addr; r_length = len; r_size = size;
    #1 check_eq({tag, "_r_rdy"}, r_rdy, 1);
    @(negedge clk);
    r_req = 1'b0; r_addr = '0; r_length = '0; r_size = '0;
    for (int i = 0; i < ar_wait; i++) begin
      #1 check_eq({tag, "_arvalid_hold"}, axi.arvalid, 1);
      check_eq({tag, "_araddr_hold"}, axi.araddr, addr);
      @(negedge clk);
    end
    axi.arready = 1'b1;
    #1 check_eq({tag, "_arvalid"}, axi.arvalid, 1);
    check_eq({tag, "_araddr"}, axi.araddr, addr);
    check_eq({tag, "_arlen"}, axi.arlen, len);
    check_eq({tag, "_arsize"}, axi.arsize, size);
    check_eq({tag, "_arburst"}, axi.arburst, 2'b01);
    check_eq({tag, "_arid"}, axi.arid, 4'd1);
    @(negedge clk);
    axi.arready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 300) begin
      axi.rvalid   = (cyc % 3) != 1;
      r_data_ready = (cyc % 5) != 3;
      axi.rdata    = 32'hA000_0000 + beat;
      axi.rlast    = (beat == len);
      axi.rresp    = (beat == 2) ? 2'b10 : 2'b00;
      #1 check_eq({tag, "_ret_valid"}, ret_valid, axi.rvalid);
      check_eq({tag, "_rready"}, axi.rready, r_data_ready);
      if (axi.rvalid) begin
        check_eq({tag, "_ret_data"}, ret_data, 32'hA000_0000 + beat);
        check_eq({tag, "_ret_last"}, ret_last, beat == len);
      end
      if (axi.rvalid && r_data_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_r_timeout"}, cyc < 300, 1);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = '0; r_data_ready = 1'b0;
    #1 check_eq({tag, "_r_rdy_after"}, r_rdy, 1);
    check_eq({tag, "_rready_after"}, axi.rready, 0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                          input int unsigned aw_wait, input string tag);
    int unsigned beat;
    int unsigned cyc;
    logic [3:0]  idx;
    logic [3:0]  start;
    start = addr[5:2];
    w_req = 1'b1; w_addr = addr; w_length = len; w_size = 3'b010;
    w_line = tb_line; w_strb = strb;
    #1 check_eq({tag, "_w_rdy"}, w_rdy, 1);
    @(negedge clk);
    w_req = 1'b0; w_addr = '0; w_line = '0; w_strb = '0; w_length = '0;
    for (int i = 0; i < aw_wait; i++) begin
      #1 check_eq({tag, "_awvalid_hold"}, axi.awvalid, 1);
      check_eq({tag, "_awaddr_hold"}, axi.awaddr, addr);
      check_eq({tag, "_wvalid_early"}, axi.wvalid, 0);
      @(negedge clk);
    end
    axi.awready = 1'b1;
    #1 check_eq({tag, "_awvalid"}, axi.awvalid, 1);
    check_eq({tag, "_awaddr"}, axi.awaddr, addr);
    check_eq({tag, "_awlen"}, axi.awlen, len);
    check_eq({tag, "_awburst"}, axi.awburst, 2'b01);
    check_eq({tag, "_awid"}, axi.awid, 4'd1);
    @(negedge clk);
    axi.awready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 200) begin
      axi.wready = (cyc % 4) != 2;
      idx = start + beat[3:0];
      #1 check_eq({tag, "_wvalid"}, axi.wvalid, 1);
      check_eq({tag, "_wdata"}, axi.wdata, tb_line[idx*32 +: 32]);
      check_eq({tag, "_wstrb"}, axi.wstrb, (len == 0) ? strb : 4'hF);
      check_eq({tag, "_wlast"}, axi.wlast, beat == len);
      check_eq({tag, "_fin_early"}, wrt_finish, 0);
      if (axi.wready) beat++;
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_w_timeout"}, cyc < 200, 1);
    axi.wready = 1'b0;
    #1 check_eq({tag, "_wvalid_done"}, axi.wvalid, 0);
    check_eq({tag, "_bready"}, axi.bready, 1);
    check_eq({tag, "_fin_wait"}, wrt_finish, 0);
    @(negedge clk);
    axi.bvalid = 1'b1;
    #1 check_eq({tag, "_fin"}, wrt_finish, 1);
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1 check_eq({tag, "_fin_drop"}, wrt_finish, 0);
    check_eq({tag, "_w_rdy_after"}, w_rdy, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    r_req = 1'b0; r_addr = '0; r_length = '0; r_size = '0; r_data_ready = 1'b0;
    w_req = 1'b0; w_addr = '0; w_length = '0; w_size = '0; w_line = '0; w_strb = '0;
    axi.arready = 1'b0; axi.rid = 4'd1; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = 4'd1; axi.bresp = '0; axi.bvalid = 1'b0;
    for (int k = 0; k < 16; k++) tb_line[k*32 +: 32] = 32'h100 + k;

    @(negedge clk);
    @(negedge clk);
    #1 check_eq("rst_r_rdy", r_rdy, 1);
    check_eq("rst_w_rdy", w_rdy, 1);
    check_eq("rst_arvalid", axi.arvalid, 0);
    check_eq("rst_awvalid", axi.awvalid, 0);
    check_eq("rst_wvalid", axi.wvalid, 0);
    check_eq("rst_rready", axi.rready, 0);
    check_eq("rst_bready", axi.bready, 0);
    check_eq("rst_ret_valid", ret_valid, 0);
    check_eq("rst_wrt_finish", wrt_finish, 0);
    check_eq("rst_araddr", axi.araddr, 0);
    check_eq("rst_awlen", axi.awlen, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    do_read(32'h1000_0040, 8'd15, 3'b010, 1, "refill");
    do_read(32'hBFD0_0004, 8'd0, 3'b001, 0, "unc_rd");
    do_write(32'h3000_0000, 8'd15, 4'h0, 3, "wb_line");
    do_write(32'h4000_0038, 8'd0, 4'b1100, 0, "unc_st");
    do_write(32'h4000_0038, 8'd3, 4'h0, 1, "wb_wrap");

    // Hazard: write to line 0x2000_0000 held in AW while reads arrive.
    w_req = 1'b1; w_addr = 32'h2000_0000; w_length = 8'd0; w_size = 3'b010;
    w_line = tb_line; w_strb = 4'hF;
    @(negedge clk);
    w_req = 1'b0;
    r_req = 1'b1; r_addr = 32'h2000_0020; r_length = 8'd0; r_size = 3'b010;
    #1 check_eq("haz_blocked0", r_rdy, 0);
    @(negedge clk);
    #1 check_eq("haz_blocked1", r_rdy, 0);
    check_eq("haz_no_ar", axi.arvalid, 0);
    r_addr = 32'h2000_0040;
    #1 check_eq("haz_other_line", r_rdy, 1);
    @(negedge clk);
    r_req = 1'b0;
    axi.arready = 1'b1;
    #1 check_eq("haz_other_araddr", axi.araddr, 32'h2000_0040);
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h5555_AAAA; r_data_ready = 1'b1;
    #1 check_eq("haz_other_ret", ret_data, 32'h5555_AAAA);
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; r_data_ready = 1'b0;
    r_req = 1'b1; r_addr = 32'h2000_0020;
    #1 check_eq("haz_blocked2", r_rdy, 0);
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0; axi.wready = 1'b1;
    #1 check_eq("haz_blocked_w", r_rdy, 0);
    check_eq("haz_wvalid", axi.wvalid, 1);
    @(negedge clk);
    axi.wready = 1'b0; axi.bvalid = 1'b1;
    #1 check_eq("haz_fin", wrt_finish, 1);
    check_eq("haz_blocked_b", r_rdy, 0);
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1 check_eq("haz_released", r_rdy, 1);
    @(negedge clk);
    r_req = 1'b0;
    axi.arready = 1'b1;
    #1 check_eq("haz_late_arvalid", axi.arvalid, 1);
    check_eq("haz_late_araddr", axi.araddr, 32'h2000_0020);
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h1234_5678; r_data_ready = 1'b1;
    #1 check_eq("haz_late_last", ret_last, 1);
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; r_data_ready = 1'b0;
    #1 check_eq("haz_idle", r_rdy, 1);
    @(negedge clk);

    // Reset while beat 5 of a line write-back is on the W channel.
    w_req = 1'b1; w_addr = 32'h5000_0000; w_length = 8'd15; w_size = 3'b010;
    w_line = tb_line; w_strb = 4'h0;
    @(negedge clk);
    w_req = 1'b0;
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0; axi.wready = 1'b1;
    repeat (5) @(negedge clk);
    #1 check_eq("rstw_wvalid", axi.wvalid, 1);
    check_eq("rstw_beat5", axi.wdata, 32'h105);
    #1 rstn = 1'b0;
    #1 check_eq("rstw_wvalid_drop", axi.wvalid, 0);
    check_eq("rstw_awvalid", axi.awvalid, 0);
    check_eq("rstw_bready", axi.bready, 0);
    check_eq("rstw_fin", wrt_finish, 0);
    check_eq("rstw_r_rdy", r_rdy, 1);
    check_eq("rstw_w_rdy", w_rdy, 1);
    axi.wready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    axi.bvalid = 1'b1;
    #1 check_eq("rstw_no_fin", wrt_finish, 0);
    @(negedge clk);
    #1 check_eq("rstw_no_fin2", wrt_finish, 0);
    check_eq("rstw_w_rdy2", w_rdy, 1);
    axi.bvalid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
# dcache_axi_bridge

Responder for the data-cache miss/write-back request interface. Accepts line-refill and uncached read requests from the dcache main FSM and returns data as a beat stream. Accepts dirty-line write-backs and uncached stores and reports completion. Sits between the dcache controller and the core's AXI4 master port, with independent read and write engines.

## Interface
Parameters:
- LINE_WORDS, 16, 32-bit words per cache line (line is 512 bits).
- WR_ID, 4'd1, AXI AWID value.
- RD_ID, 4'd1, AXI ARID value.

Ports (clock `clk`, reset `rstn`; one clock, reset asynchronous active-low):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- r_req  in  1  cache read request, held until accepted
- r_addr  in  32  read byte address (line-aligned for refills)
- r_length  in  8  AXI beats minus 1 (15 refill, 0 uncached)
- r_size  in  3  AXI size (3'b010 refill)
- r_rdy  out  1  read request accepted this cycle when r_req&&r_rdy
- r_data_ready  in  1  cache ready to take a return beat
- ret_valid  out  1  return beat valid
- ret_data  out  32  return beat data
- ret_last  out  1  final return beat
- w_req  in  1  cache write request, held until accepted
- w_addr  in  32  write byte address
- w_length  in  8  beats minus 1 (15 line, 0 uncached)
- w_size  in  3  AXI size
- w_line  in  512  write-back line, or store word at its line position
- w_strb  in  4  byte strobe for single-beat writes
- w_rdy  out  1  write request accepted when w_req&&w_rdy
- wrt_finish  out  1  one-cycle pulse on B handshake
- AXI AR: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid out; arready in
- AXI R: rid 4, rdata 32, rresp 2, rlast 1, rvalid in; rready out
- AXI AW: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid out; awready in
- AXI W: wdata 32, wstrb 4, wlast 1, wvalid out; wready in
- AXI B: bid 4, bresp 2, bvalid in; bready out

## Operation
- Read FSM R_IDLE→R_AR→R_DATA→R_IDLE.
  - r_rdy = (R_IDLE) && !hazard. Acceptance latches addr/length/size and moves to R_AR.
  - R_AR: arvalid=1 with the latched fields, arburst=2'b01 (INCR). Move to R_DATA on arready.
  - R_DATA: ret_valid=rvalid, ret_data=rdata, ret_last=rlast, rready=r_data_ready. This is a combinational pass-through.
  - Return to R_IDLE on rvalid&&rready&&rlast. rresp is ignored; the beat is still forwarded.
- Write FSM W_IDLE→W_AW→W_DATA→W_RESP→W_IDLE.
  - w_rdy = (W_IDLE). Acceptance latches addr/length/size/line/strb.
  - Beat counter cnt is loaded with start=w_addr[5:2].
  - W_AW: awvalid=1, awburst=2'b01. Move to W_DATA on awready.
  - W_DATA: wvalid=1, wdata=line[32*cnt +: 32].
    - wstrb = latched w_strb if length==0, else 4'hF.
    - wlast = (beats sent == length).
    - cnt increments mod 16 on each wready.
    - Move to W_RESP after the last beat handshakes.
  - W_RESP: bready=1. On bvalid, pulse wrt_finish and return to W_IDLE. bresp is ignored.
- Hazard: hazard=1 while the write FSM is not W_IDLE and r_addr[31:6]==latched w_addr[31:6]. This blocks reads from overtaking a pending write to the same line.
- Both engines run concurrently. The AR and AW channels are never mutually blocked except by the hazard.
- Simultaneous r_req and w_req are both accepted in the same cycle if allowed.

## Timing
- Reset: all FSMs go to idle. r_rdy=1, w_rdy=1 (idle, no hazard). All other outputs are 0, including arvalid, awvalid, wvalid, rready, bready, ret_valid, wrt_finish, and all address/length fields.
- Reset mid-burst abandons the transaction with no completion pulse.
- arvalid rises the cycle after request acceptance (minimum 1 cycle request-to-AR).
- arvalid and the AR fields stay stable until arready. The same rule applies to AW and to W beats.
- Return latency is zero: ret_valid follows rvalid in the same cycle.
- Minimum write-back time is 1 (AW) + length+1 (W) + 1 cycles before wrt_finish.
- wrt_finish fires in the same cycle as the bvalid&&bready handshake.
- The counter wrap from word 15 to word 0 is legal for unaligned start addresses.

## Structure
- Package dcache_axi_pkg holds:
  - read and write state encodings (one-hot, 3 and 4 bits);
  - BURST_INCR=2'b01;
  - SIZE_WORD=3'b010;
  - LINE_WORDS.
- Sub-module axi_line_serializer contains the latched 512-bit line, cnt, beat count, and wlast generation. It is instantiated by the write engine.

## Test plan
- Refill: r_req with addr 0x1000_0040, len 15; slave returns 16 beats 0..15 with random rvalid gaps → AR carries arlen=15, arsize=2, arburst=1. Cache sees 16 beats in order, ret_last on beat 15. The FSM is in R_IDLE the next cycle.
- Uncached read: addr 0xBFD0_0004, len 0, size 1 → one-beat AR with arlen=0, arsize=1. ret_last accompanies the single beat.
- Line write-back: len 15, line word k=k+0x100, slow awready (3-cycle delay) → 16 W beats 0x100..0x10F with wstrb=F, wlast on the 16th beat. wrt_finish pulses exactly one cycle at bvalid.
- Uncached store: addr 0x...0038, len 0, strb 4'b1100 → a single beat carrying line word 14, with wstrb=4'b1100 and wlast=1.
- Hazard: a write to 0x2000_0000 is pending and a read to 0x2000_0020 arrives → r_rdy stays 0 until wrt_finish, then accepts. A read to 0x2000_0040 issued concurrently is accepted immediately.
- Reset during W_DATA beat 5 → all valids drop asynchronously, no wrt_finish, and r_rdy=w_rdy=1 after reset.
